// File: rtl/tthbif_tx_arb.sv
// Two-requester frame arbiter feeding the tthbif serializer: round-robin grant, locked per frame.
// Define TTHBIF_ARB_WDOG_EN to build in the owner-stall watchdog that force-aborts a frame.
module tthbif_tx_arb #(
   parameter int WDOG_CYCLES = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic       r0_valid_i,
   input  logic [7:0] r0_data_i,
   input  logic       r0_last_i,
   output logic       r0_ready_o,
   input  logic       r1_valid_i,
   input  logic [7:0] r1_data_i,
   input  logic       r1_last_i,
   output logic       r1_ready_o,
   output logic       tx_valid_o,
   output logic [7:0] tx_data_o,
   output logic       tx_last_o,
   input  logic       tx_ready_i,
   output logic       owner_o,
   output logic       busy_o,
   output logic       abort_o
);

   if (WDOG_CYCLES < 2 || WDOG_CYCLES > 255) begin : g_bad_wdog
      $error("WDOG_CYCLES must be in 2..255");
   end

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t state_q, state_d;
   logic   rr_q, rr_d;
   logic   owner_q, owner_d;
   logic   own_valid, own_last;
   logic   busy;

   assign own_valid = owner_q ? r1_valid_i : r0_valid_i;
   assign own_last  = owner_q ? r1_last_i  : r0_last_i;
   assign busy      = (state_q == ST_BUSY);

`ifdef TTHBIF_ARB_WDOG_EN
   localparam logic [7:0] WDOG_LIMIT = 8'(WDOG_CYCLES - 1);
   logic [7:0] wdog_q, wdog_d;
   logic       abort_q, abort_d;
`endif

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      owner_d = owner_q;
`ifdef TTHBIF_ARB_WDOG_EN
      wdog_d  = wdog_q;
      abort_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef TTHBIF_ARB_WDOG_EN
            wdog_d = 8'd0;
`endif
            if (en_i && (r0_valid_i || r1_valid_i)) begin
               state_d = ST_BUSY;
               // rr only breaks ties; a lone requester wins regardless of the pointer
               owner_d = (r0_valid_i && r1_valid_i) ? rr_q : r1_valid_i;
            end
         end
         ST_BUSY: begin
            if (own_valid && tx_ready_i && own_last) begin
               state_d = ST_IDLE;
               rr_d    = ~owner_q;
            end
`ifdef TTHBIF_ARB_WDOG_EN
            if (own_valid) begin
               wdog_d = 8'd0;
            end else if (wdog_q == WDOG_LIMIT) begin
               state_d = ST_IDLE;
               rr_d    = ~owner_q;
               abort_d = 1'b1;
               wdog_d  = 8'd0;
            end else begin
               wdog_d = wdog_q + 8'd1;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         rr_q    <= 1'b0;
         owner_q <= 1'b0;
`ifdef TTHBIF_ARB_WDOG_EN
         wdog_q  <= 8'd0;
         abort_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
`ifdef TTHBIF_ARB_WDOG_EN
         wdog_q  <= wdog_d;
         abort_q <= abort_d;
`endif
      end
   end

   // Handshake is masked during reset so a frame in flight cannot complete a partial transfer
   assign tx_valid_o = busy && !rst_i && own_valid;
   assign tx_data_o  = owner_q ? r1_data_i : r0_data_i;
   assign tx_last_o  = own_last;
   assign r0_ready_o = busy && !rst_i && !owner_q && tx_ready_i;
   assign r1_ready_o = busy && !rst_i &&  owner_q && tx_ready_i;
   assign owner_o    = owner_q;
   assign busy_o     = busy;
`ifdef TTHBIF_ARB_WDOG_EN
   assign abort_o    = abort_q;
`else
   assign abort_o    = 1'b0;
`endif

endmodule

// File: tb/tb_tthbif_tx_arb.sv
// Directed bench for tthbif_tx_arb: queue-fed requesters, a frame-level reference model checked
// every cycle, and literal expectations for the key scenarios. Honours TTHBIF_ARB_WDOG_EN.
module tb_tthbif_tx_arb;
   localparam int WDOG = 4;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1, en_i = 1'b0, tx_ready_i = 1'b0;
   logic       r0_valid_i = 1'b0, r0_last_i = 1'b0, r1_valid_i = 1'b0, r1_last_i = 1'b0;
   logic [7:0] r0_data_i = 8'h00, r1_data_i = 8'h00;
   logic       r0_ready_o, r1_ready_o, tx_valid_o, tx_last_o, owner_o, busy_o, abort_o;
   logic [7:0] tx_data_o;

   int n_tests = 0, n_fail = 0;
   logic [8:0] q0[$], q1[$];
   logic [7:0] xlog[$];
   logic       hs0 = 1'b0, hs1 = 1'b0;

   bit m_known = 0, m_busy = 0, m_owner = 0, m_rr = 0, m_abort = 0;
   int m_stall = 0;
   bit ov, ol;
   logic [7:0] od;

   always #10 clk = ~clk;

   tthbif_tx_arb #(.WDOG_CYCLES(WDOG)) dut (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
      .r0_valid_i(r0_valid_i), .r0_data_i(r0_data_i), .r0_last_i(r0_last_i), .r0_ready_o(r0_ready_o),
      .r1_valid_i(r1_valid_i), .r1_data_i(r1_data_i), .r1_last_i(r1_last_i), .r1_ready_o(r1_ready_o),
      .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_last_o(tx_last_o), .tx_ready_i(tx_ready_i),
      .owner_o(owner_o), .busy_o(busy_o), .abort_o(abort_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #4;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
   endtask

   // Requester sources: present queue head, pop after an observed handshake
   always @(posedge clk) begin
      #3;
      if (hs0 && q0.size() > 0) void'(q0.pop_front());
      if (hs1 && q1.size() > 0) void'(q1.pop_front());
      r0_valid_i = (q0.size() > 0);
      {r0_last_i, r0_data_i} = (q0.size() > 0) ? q0[0] : 9'h0;
      r1_valid_i = (q1.size() > 0);
      {r1_last_i, r1_data_i} = (q1.size() > 0) ? q1[0] : 9'h0;
   end

   // Reference model compare and update, once per cycle mid-period
   always @(negedge clk) begin
      hs0 = r0_valid_i & r0_ready_o;
      hs1 = r1_valid_i & r1_ready_o;
      if (tx_valid_o && tx_ready_i) xlog.push_back(tx_data_o);
      ov = m_owner ? r1_valid_i : r0_valid_i;
      ol = m_owner ? r1_last_i : r0_last_i;
      od = m_owner ? r1_data_i : r0_data_i;
      if (m_known) begin
         chk("m_busy", busy_o, m_busy);
         chk("m_owner", owner_o, m_owner);
         chk("m_abort", abort_o, m_abort);
         chk("m_tx_valid", tx_valid_o, m_busy && !rst_i && ov);
         chk("m_r0_ready", r0_ready_o, m_busy && !rst_i && !m_owner && tx_ready_i);
         chk("m_r1_ready", r1_ready_o, m_busy && !rst_i && m_owner && tx_ready_i);
         if (m_busy && !rst_i && ov) begin
            chk("m_tx_data", tx_data_o, od);
            chk("m_tx_last", tx_last_o, ol);
         end
      end
      if (rst_i) begin
         m_known = 1; m_busy = 0; m_owner = 0; m_rr = 0; m_abort = 0; m_stall = 0;
      end else begin
         m_abort = 0;
         if (!m_busy) begin
            m_stall = 0;
            if (en_i && (r0_valid_i || r1_valid_i)) begin
               m_busy  = 1;
               m_owner = (r0_valid_i && r1_valid_i) ? m_rr : r1_valid_i;
            end
         end else if (ov && tx_ready_i && ol) begin
            m_busy = 0;
            m_rr   = !m_owner;
            m_stall = 0;
         end
`ifdef TTHBIF_ARB_WDOG_EN
         else if (ov) m_stall = 0;
         else if (m_stall == WDOG - 1) begin
            m_busy = 0; m_rr = !m_owner; m_abort = 1; m_stall = 0;
         end else m_stall++;
`endif
      end
   end

   initial begin
      int seen, busy_at;
      logic [7:0] exp_seq[6];
      step();
      step();
      chk("reset_busy", busy_o, 0);
      chk("reset_abort", abort_o, 0);
      chk("reset_owner", owner_o, 0);
      chk("reset_tx_valid", tx_valid_o, 0);
      rst_i = 1'b0; en_i = 1'b1; tx_ready_i = 1'b1;

      // single requester, 3-byte frame
      q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b0, 8'hA2}); q0.push_back({1'b1, 8'hA3});
      step(); chk("single_latency_busy", busy_o, 0);
      step(); chk("single_busy", busy_o, 1); chk("single_b0", tx_data_o, 8'hA1);
      step(); chk("single_b1", tx_data_o, 8'hA2);
      step(); chk("single_b2", tx_data_o, 8'hA3); chk("single_last", tx_last_o, 1);
      step(); chk("single_release", busy_o, 0); chk("single_owner", owner_o, 0);

      // contention from reset: alternation, no interleaving
      do_reset();
      q0.push_back({1'b0, 8'hB0}); q0.push_back({1'b1, 8'hB1});
      q0.push_back({1'b0, 8'hB2}); q0.push_back({1'b1, 8'hB3});
      q1.push_back({1'b0, 8'hC0}); q1.push_back({1'b1, 8'hC1});
      xlog.delete();
      for (int i = 0; i < 40 && xlog.size() < 6; i++) step();
      chk("contend_count", xlog.size(), 6);
      exp_seq = '{8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hB2, 8'hB3};
      for (int i = 0; i < 6; i++) chk("contend_order", (i < xlog.size()) ? xlog[i] : 8'hxx, exp_seq[i]);

      // backpressure during an r1 frame
      do_reset();
      q1.push_back({1'b0, 8'hD0}); q1.push_back({1'b0, 8'hD1}); q1.push_back({1'b1, 8'hD2});
      step(); chk("bp_latency", busy_o, 0);
      step(); chk("bp_owner", owner_o, 1); chk("bp_d0", tx_data_o, 8'hD0);
      step(); tx_ready_i = 1'b0; #1;
      chk("bp_d1", tx_data_o, 8'hD1); chk("bp_r1_ready0", r1_ready_o, 0); chk("bp_r0_ready", r0_ready_o, 0);
      step(); chk("bp_d1_hold", tx_data_o, 8'hD1); tx_ready_i = 1'b1; #1;
      chk("bp_r1_ready1", r1_ready_o, 1); chk("bp_r0_ready_b", r0_ready_o, 0);
      step(); chk("bp_d2", tx_data_o, 8'hD2); tx_ready_i = 1'b0;
      step(); chk("bp_d2_hold", tx_data_o, 8'hD2); tx_ready_i = 1'b1;
      step(); chk("bp_release", busy_o, 0);

      // reset mid-frame, then rr=0 favours r0
      do_reset();
      for (int i = 0; i < 4; i++) q0.push_back({(i == 3), 8'hE0 + 8'(i)});
      for (int i = 0; i < 10 && !(tx_valid_o && tx_data_o == 8'hE0); i++) step();
      chk("rstmid_first", tx_data_o, 8'hE0);
      step(); chk("rstmid_second", tx_data_o, 8'hE1);
      rst_i = 1'b1; #1;
      chk("rstmid_txv_in_rst", tx_valid_o, 0); chk("rstmid_r0rdy_in_rst", r0_ready_o, 0);
      chk("rstmid_r1rdy_in_rst", r1_ready_o, 0);
      q0.delete();
      step(); chk("rstmid_busy", busy_o, 0); chk("rstmid_txv", tx_valid_o, 0);
      rst_i = 1'b0;
      q0.push_back({1'b1, 8'h60}); q1.push_back({1'b1, 8'hF0});
      xlog.delete();
      for (int i = 0; i < 12 && xlog.size() < 2; i++) step();
      chk("rstmid_count", xlog.size(), 2);
      chk("rstmid_r0_first", (xlog.size() > 0) ? xlog[0] : 8'hxx, 8'h60);
      chk("rstmid_r1_next", (xlog.size() > 1) ? xlog[1] : 8'hxx, 8'hF0);

      // enable gating, and lock survives en_i falling
      do_reset();
      en_i = 1'b0;
      q0.push_back({1'b0, 8'h70}); q0.push_back({1'b1, 8'h71});
      for (int i = 0; i < 3; i++) begin step(); chk("en_off_busy", busy_o, 0); end
      en_i = 1'b1;
      step(); chk("en_on_busy", busy_o, 1); chk("en_on_data", tx_data_o, 8'h70);
      en_i = 1'b0;
      step(); chk("en_drop_locked", busy_o, 1); chk("en_drop_data", tx_data_o, 8'h71);
      step(); chk("en_drop_release", busy_o, 0);
      en_i = 1'b1;

      // owner stall after one non-last byte
      do_reset();
      q0.push_back({1'b0, 8'h90});
      step(); step(); chk("wd_byte", tx_data_o, 8'h90);
      step(); chk("wd_drop_busy", busy_o, 1); chk("wd_drop_txv", tx_valid_o, 0);
`ifdef TTHBIF_ARB_WDOG_EN
      seen = -1; busy_at = -1;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (abort_o === 1'b1 && seen < 0) begin seen = i; busy_at = busy_o; end
      end
      chk("wd_abort_delay", seen, 4);
      chk("wd_abort_busy", busy_at, 0);
`else
      seen = 0; busy_at = 0;
      repeat (20) step();
      chk("nowd_still_busy", busy_o, 1);
      chk("nowd_no_abort", abort_o, 0);
      q0.push_back({1'b1, 8'h91});
      step(); step(); step();
      chk("nowd_release", busy_o, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
